// File: rtl/tetris_pkg.sv
// Shared definitions for the playfield: row command codes, sequencer states
// and the lowest-full-row picker used when clearing lines.
package tetris_pkg;

  localparam int MAX_ROWS = 64;

  typedef enum logic [2:0] {
    CMD_CHECK = 3'b000,
    CMD_MOVE  = 3'b001,
    CMD_WRITE = 3'b010,
    CMD_SHIFT = 3'b011,
    CMD_ADD   = 3'b100
  } row_cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADD,
    ST_SPAWNCHK,
    ST_WAIT,
    ST_MOVE,
    ST_WRITE,
    ST_CHECK,
    ST_SHIFT,
    ST_HALT
  } seq_state_t;

  // Index of the lowest set bit; callers turn it into a one-hot select.
  function automatic int unsigned lowest_set_index(input logic [MAX_ROWS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_ROWS - 1; i >= 0; i--) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/row_sequencer_if.sv
// Broadcast bus between the sequencer and the row instances: command and
// shift select out, OR-reduced status and per-row full flags back.
interface row_sequencer_if #(
  parameter int ROWS = 20
);
  logic [2:0]      state;
  logic [ROWS-1:0] shift_sel;
  logic            stop;
  logic            endgame_in;
  logic [ROWS-1:0] full_row;

  modport master (
    output state,
    output shift_sel,
    input  stop,
    input  endgame_in,
    input  full_row
  );

  modport slave (
    input  state,
    input  shift_sel,
    output stop,
    output endgame_in,
    output full_row
  );
endinterface

// File: rtl/row_sequencer_drop_timer.sv
// Gravity tick counter: counts ticks while enabled and pulses expire on the
// tick that reaches the threshold (a count already past it expires too).
module drop_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       tick,
  input  logic [7:0] threshold,
  output logic       expire
);

  logic [7:0] count_reg, count_next;

  always_comb begin
    expire     = enable && tick && (({1'b0, count_reg} + 9'd1) >= {1'b0, threshold});
    count_next = count_reg;
    if (clear || expire) begin
      count_next = '0;
    end else if (enable && tick) begin
      count_next = count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_reg <= '0;
    else        count_reg <= count_next;
  end

endmodule

// File: rtl/row_sequencer.sv
// Gameplay-loop controller driving the row command bus.
// Optional SOFT_DROP_EN adds drop_fast, shrinking the gravity threshold to 1 tick.
module row_sequencer
  import tetris_pkg::*;
#(
  parameter int ROWS       = 20,
  parameter int DROP_TICKS = 30,
  parameter int LINES_W    = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
`ifdef SOFT_DROP_EN
  input  logic               drop_fast,
`endif
  row_sequencer_if.master    rows,
  output logic [LINES_W-1:0] lines,
  output logic               game_over,
  output logic               busy
);

  localparam logic [7:0] DROP_THRESH = 8'(DROP_TICKS);

  seq_state_t           state_reg, state_next;
  logic [ROWS-1:0]      shift_sel_reg, shift_sel_next;
  logic [LINES_W-1:0]   lines_reg, lines_next;
  logic [MAX_ROWS-1:0]  full_ext;
  logic [7:0]           threshold;
  logic                 timer_clear;
  logic                 timer_expire;
  logic                 timer_enable;

`ifdef SOFT_DROP_EN
  assign threshold = drop_fast ? 8'd1 : DROP_THRESH;
`else
  assign threshold = DROP_THRESH;
`endif

  assign timer_enable = (state_reg == ST_WAIT);

  drop_timer u_drop_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .enable    (timer_enable),
    .tick      (tick),
    .threshold (threshold),
    .expire    (timer_expire)
  );

  always_comb begin
    state_next     = state_reg;
    shift_sel_next = shift_sel_reg;
    lines_next     = lines_reg;
    timer_clear    = 1'b0;
    rows.state     = CMD_CHECK;
    full_ext       = '0;
    full_ext[ROWS-1:0] = rows.full_row;

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_ADD;
      end
      ST_ADD: begin
        rows.state = CMD_ADD;
        state_next = ST_SPAWNCHK;
      end
      // endgame_in is registered by the rows during ADD, so it is only valid here.
      ST_SPAWNCHK: begin
        if (rows.endgame_in) begin
          state_next = ST_HALT;
        end else begin
          state_next  = ST_WAIT;
          timer_clear = 1'b1;
        end
      end
      ST_WAIT: begin
        if (timer_expire) state_next = rows.stop ? ST_WRITE : ST_MOVE;
      end
      ST_MOVE: begin
        rows.state  = CMD_MOVE;
        state_next  = ST_WAIT;
        timer_clear = 1'b1;
      end
      ST_WRITE: begin
        rows.state = CMD_WRITE;
        state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (|rows.full_row) begin
          state_next     = ST_SHIFT;
          shift_sel_next = ROWS'(1) << lowest_set_index(full_ext);
        end else begin
          state_next = ST_ADD;
        end
      end
      ST_SHIFT: begin
        rows.state     = CMD_SHIFT;
        shift_sel_next = '0;
        state_next     = ST_CHECK;
        if (lines_reg != '1) lines_next = lines_reg + LINES_W'(1);
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      shift_sel_reg <= '0;
      lines_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      shift_sel_reg <= shift_sel_next;
      lines_reg     <= lines_next;
    end
  end

  assign rows.shift_sel = shift_sel_reg;
  assign lines          = lines_reg;
  assign game_over      = (state_reg == ST_HALT);
  assign busy           = (state_reg != ST_IDLE) && (state_reg != ST_HALT);

endmodule

// File: doc/row_sequencer.md
Name: row_sequencer

Overview:
- Central controller for the per-row block datapath; owns the 3-bit `state` bus broadcast to every row instance.
- Sequences the gameplay loop:
  - spawn piece
  - gravity wait
  - move down
  - lock (write) on collision
  - scan for full rows
  - shift down, once per cleared row
  - respawn
- Consumes the OR-reduced `stop`/`endgame` flags and the per-row full flags; produces the row-shift select, a cleared-lines counter and the game-over flag.

Parameters:
- ROWS, 20, number of playfield rows; width of `full_row` and `shift_sel`.
- DROP_TICKS, 30, frame ticks per gravity step; must be 1..255.
- LINES_W, 14, width of the cleared-lines counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that leaves IDLE.
- tick  in  1  one-cycle frame strobe.
- stop  in  1  OR of all rows' Stop; combinational from the rows.
- endgame_in  in  1  OR of all rows' endgame; registered in the rows.
- full_row  in  ROWS  bit i = row i fully occupied; bit 0 = bottom row.
- state  out  3  row command: 000 check/hold, 001 move, 010 write, 011 shift, 100 add.
- shift_sel  out  ROWS  one-hot; the row being cleared during SHIFT; all zero otherwise.
- lines  out  LINES_W  total cleared rows; saturates at all-ones.
- game_over  out  1  sticky end-of-game flag.
- busy  out  1  high in every state except IDLE and HALT.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM enters IDLE.
  - state=000, shift_sel=0, lines=0, game_over=0, busy=0.
  - Drop timer = 0.
- Deasserting reset mid-operation restarts cleanly from IDLE. No partial command is ever re-issued.
- Internal FSM states and the `state` code each one drives:
  - IDLE → 000
  - ADD → 100
  - SPAWNCHK → 000
  - WAIT → 000
  - MOVE → 001
  - WRITE → 010
  - CHECK → 000
  - SHIFT → 011
  - HALT → 000
- FSM transitions:
  - IDLE: on start=1 → ADD.
  - ADD: 1 cycle, then → SPAWNCHK.
  - SPAWNCHK: 1 cycle. This state exists because endgame_in is registered in the rows during ADD.
    - endgame_in=1 → HALT.
    - otherwise → WAIT; timer cleared.
  - WAIT: timer increments on each tick.
    - When a tick arrives with timer == DROP_TICKS-1: stop=0 → MOVE; stop=1 → WRITE.
    - Ticks in any other state are ignored and not queued.
  - MOVE: 1 cycle, then → WAIT; timer cleared.
  - WRITE: 1 cycle, then → CHECK.
  - CHECK: one cycle of settle/scan.
    - full_row != 0 → SHIFT; latch the lowest set bit, one-hot, into shift_sel.
    - full_row == 0 → ADD.
  - SHIFT: 1 cycle with shift_sel driven.
    - lines increments by 1, saturating.
    - → CHECK; shift_sel cleared on exit.
    - Each SHIFT clears exactly one row. Multiple full rows therefore take alternating CHECK/SHIFT pairs, always lowest row first.
  - HALT: game_over=1; stays in HALT until reset; start is ignored.
- Boundary rules:
  - start while busy: ignored.
  - tick and start in the same cycle in IDLE: start wins; that tick is dropped.
  - stop is sampled only on the expiring tick. A stop that rises and falls between ticks has no effect.
  - DROP_TICKS=1: every tick in WAIT triggers a step.
  - All ROWS full: exactly ROWS SHIFT cycles, then ADD.
  - lines at all-ones: holds at all-ones.
- Latency:
  - Lock without line clear: WRITE → CHECK → ADD, i.e. 3 cycles before the next spawn.

Optional Feature:
- SOFT_DROP_EN
- Defined:
  - Adds input port `drop_fast` (1 bit).
  - While drop_fast=1 in WAIT, the expiry threshold becomes 1 tick.
  - When drop_fast rises, a timer already ≥1 expires on the next tick.
- Undefined:
  - Port absent; threshold is always DROP_TICKS.

Decomposition:
- Package `tetris_pkg` holds:
  - the 3-bit row-command typedef and its constants CMD_CHECK, CMD_MOVE, CMD_WRITE, CMD_SHIFT, CMD_ADD;
  - the internal FSM state enum.
- The rows import the same command constants.
- One sub-module, `drop_timer`:
  - tick counter with clear, enable and a threshold input;
  - produces a one-cycle `expire` output.
- Lowest-set-bit one-hot extraction stays inline as a function in the package.

Test Plan:
- Reset then start, stop=0, DROP_TICKS=3 → state sequence 100, 000, then 001 after the 3rd tick in WAIT; busy=1 throughout.
- stop=1 held at the 3rd tick → 010 for one cycle, CHECK; with full_row=0 → 100 on the following cycle.
- WRITE with full_row=0x0005 → SHIFT with shift_sel=0x00001, CHECK, then (full_row now 0x00002 from the bench) SHIFT with shift_sel=0x00002, then ADD; lines=2.
- endgame_in=1 in the cycle after ADD → HALT; game_over=1, state=000; later start and tick pulses produce no change.
- reset driven low during SHIFT → outputs return to reset values immediately (asynchronously); lines=0; after release the FSM sits in IDLE.
- SOFT_DROP_EN defined, drop_fast=1 in WAIT → 001 issued on every tick; with the macro undefined the same stimulus needs DROP_TICKS ticks per move.
